tdc_avg: RTL and testbench

TDC_AVG -- requirements
Module: tdc_avg

---
 rtl/tdc_avg_pkg.sv | 14 +
 rtl/tdc_avg_fifo.sv | 45 ++++
 rtl/tdc_avg.sv | 157 +++++++++++++++
 tb/tb_tdc_avg.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tdc_avg_pkg.sv
// Shared sizing constants and FSM state type for the TDC window averager.
// Optional drop counter on tdc_avg is enabled with TDC_AVG_DROP_CNT_EN.
package tdc_avg_pkg;

  localparam int unsigned DW       = 20;
  localparam int unsigned MAX_LOG2 = 8;
  localparam int unsigned ACC_W    = DW + MAX_LOG2;

  typedef enum logic {
    S_IDLE,
    S_ACC
  } state_t;

endpackage

// File: rtl/tdc_avg_fifo.sv
// Two-entry result FIFO; a push into a full FIFO only succeeds when a pop
// happens in the same cycle.
module tdc_avg_fifo #(
  parameter int unsigned W = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         do_push;
  logic         do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 2; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(do_push) - 2'(do_pop);
    end
  end

endmodule

// File: rtl/tdc_avg.sv
// Block averager: sums 2^k samples, rounds the mean and queues it in a
// 2-deep FIFO. Define TDC_AVG_DROP_CNT_EN to add the drop_cnt output.
module tdc_avg #(
  parameter int unsigned DW       = tdc_avg_pkg::DW,
  parameter int unsigned MAX_LOG2 = tdc_avg_pkg::MAX_LOG2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dval,
  input  logic [DW-1:0] in_data,
  input  logic [3:0]    win_log2,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          o_dval,
  output logic          o_ovf,
  output logic          o_busy
`ifdef TDC_AVG_DROP_CNT_EN
  ,
  output logic [7:0]    drop_cnt
`endif
);

  import tdc_avg_pkg::*;

  localparam int unsigned AW = DW + MAX_LOG2;
  localparam int unsigned CW = MAX_LOG2 + 1;

  state_t        state, state_nx;
  logic [AW-1:0] acc;
  logic [CW-1:0] cnt;
  logic [3:0]    k_lat;
  logic [3:0]    k_in;
  logic [3:0]    k_cur;
  logic [CW-1:0] win_last;
  logic [AW-1:0] close_sum;
  logic          close;
  logic          start;

  logic          s1_vld;
  logic [AW-1:0] s1_sum;
  logic [3:0]    s1_k;
  logic [AW-1:0] rnd;
  logic [DW-1:0] res;

  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;
  logic          drop;

  assign k_in = (win_log2 > 4'(MAX_LOG2)) ? 4'(MAX_LOG2) : win_log2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // The exponent is taken live only on a window's first sample; afterwards
  // the latched copy governs, so mid-window win_log2 changes have no effect.
  always_comb begin
    state_nx  = state;
    close     = 1'b0;
    start     = 1'b0;
    k_cur     = (state == S_IDLE) ? k_in : k_lat;
    win_last  = (CW'(1) << k_cur) - CW'(1);
    close_sum = acc + AW'(in_data);
    case (state)
      S_IDLE: begin
        if (dval) begin
          if (k_in == 4'd0) begin
            close = 1'b1;
          end else begin
            start    = 1'b1;
            state_nx = S_ACC;
          end
        end
      end
      S_ACC: begin
        if (dval && (cnt == win_last)) begin
          close    = 1'b1;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      cnt   <= '0;
      k_lat <= '0;
    end else if (close) begin
      acc <= '0;
      cnt <= '0;
    end else if (dval) begin
      acc <= close_sum;
      cnt <= cnt + CW'(1);
      if (start) k_lat <= k_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s1_sum <= '0;
      s1_k   <= '0;
    end else begin
      s1_vld <= close;
      if (close) begin
        s1_sum <= close_sum;
        s1_k   <= k_cur;
      end
    end
  end

  // Round-half-up mean; the sum headroom guarantees the rounding add cannot wrap.
  always_comb begin
    rnd = s1_sum;
    res = s1_sum[DW-1:0];
    if (s1_k != 4'd0) begin
      rnd = s1_sum + (AW'(1) << (s1_k - 4'd1));
      res = DW'(rnd >> s1_k);
    end
  end

  assign pop  = o_dval & out_ready;
  assign drop = s1_vld & fifo_full & ~pop;

  tdc_avg_fifo #(
    .W (DW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (s1_vld),
    .pop   (pop),
    .din   (res),
    .dout  (out_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign o_dval = ~fifo_empty;
  assign o_busy = (state == S_ACC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       o_ovf <= 1'b0;
    else if (drop) o_ovf <= 1'b1;
  end

`ifdef TDC_AVG_DROP_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              drop_cnt <= '0;
    else if (drop && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_tdc_avg.sv
// Directed bench for tdc_avg: expected averages are queued as windows close
// and compared when the DUT hands a result downstream.
module tb_tdc_avg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dval = 1'b0;
  logic [19:0] in_data = '0;
  logic [3:0]  win_log2 = '0;
  logic        out_ready = 1'b1;
  logic [19:0] out_data;
  logic        o_dval;
  logic        o_ovf;
  logic        o_busy;
`ifdef TDC_AVG_DROP_CNT_EN
  logic [7:0]  drop_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [19:0] exp_q [$];

  tdc_avg #(
    .DW       (20),
    .MAX_LOG2 (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .dval      (dval),
    .in_data   (in_data),
    .win_log2  (win_log2),
    .out_ready (out_ready),
    .out_data  (out_data),
    .o_dval    (o_dval),
    .o_ovf     (o_ovf),
    .o_busy    (o_busy)
`ifdef TDC_AVG_DROP_CNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [19:0] d);
    dval    = 1'b1;
    in_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    dval = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: every accepted result must match the queue head.
  always @(negedge clk) begin
    logic [19:0] e;
    if (!rst && o_dval && out_ready) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_out observed=%0h expected=none", out_data);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        assert (out_data === e) else begin
          errors++;
          $error("FAIL result observed=%0h expected=%0h", out_data, e);
        end
      end
    end
  end

  initial begin
    logic [19:0] v;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_dval", 32'(o_dval), 32'h0);
    chk("rst_ovf", 32'(o_ovf), 32'h0);
    chk("rst_busy", 32'(o_busy), 32'h0);
`ifdef TDC_AVG_DROP_CNT_EN
    chk("rst_drop_cnt", 32'(drop_cnt), 32'h0);
`endif
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 4-sample window 10..13 -> 12, two-cycle latency
    win_log2 = 4'd2;
    drive(20'd10);
    chk("busy_first", 32'(o_busy), 32'h1);
    drive(20'd11);
    drive(20'd12);
    exp_q.push_back(20'd12);
    drive(20'd13);
    dval = 1'b0;
    chk("busy_closed", 32'(o_busy), 32'h0);
    @(negedge clk);
    chk("lat_w2_cyc1", 32'(o_dval), 32'h0);
    @(negedge clk);
    chk("lat_w2_cyc2", 32'(o_dval), 32'h1);
    idle(3);

    // single-sample windows
    win_log2 = 4'd0;
    exp_q.push_back(20'hABCDE);
    drive(20'hABCDE);
    dval = 1'b0;
    chk("busy_w0", 32'(o_busy), 32'h0);
    @(negedge clk);
    chk("lat_w0_cyc1", 32'(o_dval), 32'h0);
    @(negedge clk);
    chk("lat_w0_cyc2", 32'(o_dval), 32'h1);
    idle(2);
    for (int i = 0; i < 6; i++) begin
      v = 20'($urandom_range(0, 20'hFFFFF));
      exp_q.push_back(v);
      drive(v);
      if (i > 1) chk("burst_dval", 32'(o_dval), 32'h1);
      chk("burst_busy", 32'(o_busy), 32'h0);
    end
    dval = 1'b0;
    idle(4);

    // exponent 12 clamps to 8: 256 full-scale samples -> one full-scale result
    win_log2 = 4'd12;
    for (int i = 0; i < 256; i++) begin
      if (i == 255) exp_q.push_back(20'hFFFFF);
      drive(20'hFFFFF);
      if (i == 128) chk("busy_long", 32'(o_busy), 32'h1);
      if (i == 200) chk("no_early_out", 32'(o_dval), 32'h0);
    end
    dval = 1'b0;
    chk("busy_long_end", 32'(o_busy), 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("lat_w8", 32'(o_dval), 32'h1);
    idle(3);

    // mid-window exponent change is ignored until the next window
    win_log2 = 4'd2;
    drive(20'd100);
    drive(20'd200);
    win_log2 = 4'd1;
    drive(20'd300);
    chk("busy_latched_k", 32'(o_busy), 32'h1);
    exp_q.push_back(20'd250);
    drive(20'd401);
    chk("busy_after_4", 32'(o_busy), 32'h0);
    drive(20'd7);
    chk("busy_new_k", 32'(o_busy), 32'h1);
    exp_q.push_back(20'd8);
    drive(20'd8);
    chk("busy_after_2", 32'(o_busy), 32'h0);
    idle(4);

    // push and pop on a full FIFO in the same cycle: nothing dropped
    out_ready = 1'b0;
    win_log2  = 4'd0;
    exp_q.push_back(20'd9);
    exp_q.push_back(20'd10);
    exp_q.push_back(20'd11);
    drive(20'd9);
    drive(20'd10);
    drive(20'd11);
    dval = 1'b0;
    out_ready = 1'b1;
    chk("full_dval", 32'(o_dval), 32'h1);
    idle(5);
    chk("no_ovf", 32'(o_ovf), 32'h0);
`ifdef TDC_AVG_DROP_CNT_EN
    chk("no_drop_cnt", 32'(drop_cnt), 32'h0);
`endif

    // reset mid-window discards the partial sum
    win_log2 = 4'd2;
    drive(20'd50);
    drive(20'd60);
    drive(20'd70);
    dval = 1'b0;
    chk("busy_partial", 32'(o_busy), 32'h1);
    idle(2);
    chk("partial_no_out", 32'(o_dval), 32'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_busy", 32'(o_busy), 32'h0);
    chk("rst_mid_dval", 32'(o_dval), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);
    drive(20'd4);
    drive(20'd4);
    drive(20'd8);
    exp_q.push_back(20'd6);
    drive(20'd8);
    idle(4);

    // overflow: third result dropped while the downstream stalls
    out_ready = 1'b0;
    win_log2  = 4'd0;
    exp_q.push_back(20'd1);
    exp_q.push_back(20'd2);
    drive(20'd1);
    drive(20'd2);
    drive(20'd3);
    idle(4);
    chk("ovf_dval", 32'(o_dval), 32'h1);
    chk("ovf_head", 32'(out_data), 32'h1);
    chk("ovf_flag", 32'(o_ovf), 32'h1);
`ifdef TDC_AVG_DROP_CNT_EN
    chk("ovf_drop_cnt", 32'(drop_cnt), 32'h1);
`endif
    out_ready = 1'b1;
    idle(4);
    chk("ovf_drained", 32'(o_dval), 32'h0);
    chk("ovf_sticky", 32'(o_ovf), 32'h1);

    // bounded drain of anything still expected
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
    chk("sb_empty", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
